// File: rtl/axis_spi_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream to SPI round-robin arbiter.
package axis_spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int RR_MAX_SRC = 32;

  // Scalar round-robin pick: first requester after 'last', wrapping; returns 'last' when nobody requests.
  function automatic int rr_next(input logic [RR_MAX_SRC-1:0] req, input int last, input int num_src);
    int idx;
    rr_next = last;
    for (int j = num_src; j >= 1; j--) begin
      idx = (last + j) % num_src;
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/axis_spi_arb_rr_arbiter.sv
// Combinational round-robin picker: rotate a doubled request vector so the search starts
// just after the previous winner, then take the lowest set bit.
module rr_arbiter #(
  parameter int NUM_SRC  = 2,
  parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_last_idx,
  output logic [ID_WIDTH-1:0] o_gnt_idx,
  output logic                o_gnt_valid
);

  logic [2*NUM_SRC-1:0] w_dbl;
  logic [NUM_SRC-1:0]   w_rot;
  int                   w_off;
  int                   w_pos;

  always_comb begin
    w_dbl = {i_req, i_req};
    w_rot = NUM_SRC'(w_dbl >> (int'(i_last_idx) + 1));
    w_off = 0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = j;
    end
    // Rotated offset back to an absolute index, modulo NUM_SRC (need not be a power of two).
    w_pos = int'(i_last_idx) + 1 + w_off;
    if (w_pos >= NUM_SRC) w_pos = w_pos - NUM_SRC;
    o_gnt_idx   = ID_WIDTH'(w_pos);
    o_gnt_valid = |i_req;
  end

endmodule

// File: rtl/axis_spi_arb.sv
// Packet-locked round-robin mux of NUM_SRC AXI-Stream sources onto one SPI master input,
// with an idle gap after every packet so the master drops CS between frames.
module axis_spi_arb
  import axis_spi_arb_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int DATA_WIDTH = 16,
  parameter  int GAP_CYCLES = 4,
  localparam int ID_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic [ID_WIDTH-1:0]           m_tid,
  input  logic                          m_tready,
  output logic                          busy_o,
  output logic [NUM_SRC-1:0]            grant_o
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              r_state, w_state_nxt;
  logic [ID_WIDTH-1:0] r_grant_idx, w_grant_nxt;
  logic [ID_WIDTH-1:0] r_last_idx, w_last_nxt;
  logic [CNT_W-1:0]    r_gap_cnt, w_cnt_nxt;

  logic [ID_WIDTH-1:0]   w_arb_idx;
  logic                  w_arb_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic                  w_hs;

  rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .i_req       (s_tvalid),
    .i_last_idx  (r_last_idx),
    .o_gnt_idx   (w_arb_idx),
    .o_gnt_valid (w_arb_valid)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_grant_idx == ID_WIDTH'(k)) begin
        w_sel_data  = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_valid = s_tvalid[k];
        w_sel_last  = s_tlast[k];
      end
    end
  end

  assign w_hs = (r_state == XFER) && w_sel_valid && m_tready;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= ID_WIDTH'(NUM_SRC - 1);
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_nxt;
      r_last_idx  <= w_last_nxt;
      r_gap_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_idx;
    w_last_nxt  = r_last_idx;
    w_cnt_nxt   = r_gap_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_grant_nxt = w_arb_idx;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        // Grant stays locked, even across tvalid bubbles, until the tlast handshake.
        if (w_hs && w_sel_last) begin
          w_last_nxt = r_grant_idx;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = IDLE;
        else                 w_cnt_nxt   = r_gap_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    grant_o  = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    busy_o   = (r_state != IDLE);
    if (r_state == XFER) begin
      m_tdata               = w_sel_data;
      m_tvalid              = w_sel_valid;
      m_tlast               = w_sel_last;
      m_tid                 = r_grant_idx;
      s_tready[r_grant_idx] = m_tready;
      grant_o[r_grant_idx]  = 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_spi_arb.sv
// Directed bench: queue-backed AXI-Stream source models feed a 2-source/GAP=4 instance and a
// 3-source/GAP=0 instance; output beats are checked against scoreboards filled at stimulus time.
module tb_axis_spi_arb;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  tid;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  logic [31:0] a_s_tdata;
  logic [1:0]  a_s_tvalid, a_s_tlast, a_s_tready, a_grant;
  logic [15:0] a_m_tdata;
  logic        a_m_tvalid, a_m_tlast, a_m_tready, a_busy;
  logic [0:0]  a_m_tid;

  logic [47:0] b_s_tdata;
  logic [2:0]  b_s_tvalid, b_s_tlast, b_s_tready, b_grant;
  logic [15:0] b_m_tdata;
  logic        b_m_tvalid, b_m_tlast, b_m_tready, b_busy;
  logic [1:0]  b_m_tid;

  axis_spi_arb #(.NUM_SRC(2), .DATA_WIDTH(16), .GAP_CYCLES(4)) u_dut_a (
    .clk_i(clk), .arstn_i(arstn),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tlast(a_s_tlast), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast), .m_tid(a_m_tid),
    .m_tready(a_m_tready), .busy_o(a_busy), .grant_o(a_grant)
  );

  axis_spi_arb #(.NUM_SRC(3), .DATA_WIDTH(16), .GAP_CYCLES(0)) u_dut_b (
    .clk_i(clk), .arstn_i(arstn),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tlast(b_s_tlast), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast), .m_tid(b_m_tid),
    .m_tready(b_m_tready), .busy_o(b_busy), .grant_o(b_grant)
  );

  beat_t q0[$];
  beat_t q1[$];
  exp_t  sba[$];
  exp_t  sbb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic  stall0 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue a packet on a source and its expected output beats on the scoreboard.
  task automatic pkt(input int src, input int n, input logic [15:0] base);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      b.data = base + 16'(i);
      b.last = (i == n - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
      e.tid  = 2'(src);
      e.data = b.data;
      e.last = b.last;
      sba.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while ((sba.size() != 0 || q0.size() != 0 || q1.size() != 0 || a_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_in_budget"}, 32'(c < budget), 32'd1);
  endtask

  // Source models: handshake seen at negedge, pop and re-drive just after the next posedge.
  initial begin : src_drv
    logic hs0, hs1;
    a_s_tvalid = '0;
    a_s_tlast  = '0;
    a_s_tdata  = '0;
    forever begin
      @(negedge clk);
      hs0 = a_s_tvalid[0] & a_s_tready[0];
      hs1 = a_s_tvalid[1] & a_s_tready[1];
      @(posedge clk);
      #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      a_s_tvalid[0]     = (q0.size() > 0) && !stall0;
      a_s_tdata[15:0]   = (q0.size() > 0) ? q0[0].data : 16'h0;
      a_s_tlast[0]      = (q0.size() > 0) ? q0[0].last : 1'b0;
      a_s_tvalid[1]     = (q1.size() > 0);
      a_s_tdata[31:16]  = (q1.size() > 0) ? q1[0].data : 16'h0;
      a_s_tlast[1]      = (q1.size() > 0) ? q1[0].last : 1'b0;
    end
  end

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (arstn && a_m_tvalid && a_m_tready) begin
        n_cmp++;
        assert (sba.size() != 0) else begin
          n_err++;
          $error("FAIL a_unexpected_beat: observed data %0h expected no beat", a_m_tdata);
        end
        if (sba.size() != 0) begin
          e = sba.pop_front();
          check("a_tid", 32'(a_m_tid), 32'(e.tid));
          check("a_data", 32'(a_m_tdata), 32'(e.data));
          check("a_last", 32'(a_m_tlast), 32'(e.last));
          check("a_s_tready", 32'(a_s_tready), 32'(2'b01 << e.tid));
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (arstn && b_m_tvalid && b_m_tready) begin
        n_cmp++;
        assert (sbb.size() != 0) else begin
          n_err++;
          $error("FAIL b_unexpected_beat: observed tid %0d expected no beat", b_m_tid);
        end
        if (sbb.size() != 0) begin
          e = sbb.pop_front();
          check("b_tid", 32'(b_m_tid), 32'(e.tid));
          check("b_data", 32'(b_m_tdata), 32'(e.data));
          check("b_grant", 32'(b_grant), 32'(3'b001 << e.tid));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   c;
    logic v;
    exp_t e;
    arstn      = 1'b0;
    a_m_tready = 1'b0;
    b_m_tready = 1'b1;
    b_s_tvalid = 3'b000;
    b_s_tlast  = 3'b111;
    b_s_tdata  = {16'hB002, 16'hB001, 16'hB000};

    // Reset state, with m_tready high so s_tready must still be held off.
    @(negedge clk);
    a_m_tready = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_grant", 32'(a_grant), 32'd0);
    check("rst_m_tvalid", 32'(a_m_tvalid), 32'd0);
    check("rst_s_tready", 32'(a_s_tready), 32'd0);
    check("rst_m_tdata", 32'(a_m_tdata), 32'd0);
    check("rst_m_tid", 32'(a_m_tid), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    arstn = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(a_busy), 32'd0);

    // Single source, 3 beats: beats on cycles 1..3, then exactly 4 gap cycles.
    pkt(0, 3, 16'h1000);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      v = (i >= 1 && i <= 3);
      check("t1_m_tvalid", 32'(a_m_tvalid), 32'(v));
      check("t1_grant", 32'(a_grant), v ? 32'd1 : 32'd0);
      check("t1_busy", 32'(a_busy), 32'(i >= 1 && i <= 7));
    end
    wait_done("t1", 50);

    // Round robin from a fresh reset: 0,1,0,1.
    arstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    pkt(0, 2, 16'h2000);
    pkt(1, 2, 16'h2100);
    pkt(0, 2, 16'h2200);
    pkt(1, 2, 16'h2300);
    wait_done("t2", 200);

    // Backpressure on a 4-beat src1 packet: m_tready 1,0,1,0 from the first XFER cycle.
    pkt(1, 4, 16'h3000);
    for (int i = 0; i <= 12; i++) begin
      @(posedge clk);
      #2;
      a_m_tready = (i % 2 == 1);
      @(negedge clk);
      v = (i >= 1 && i <= 7);
      check("t3_s_tready1", 32'(a_s_tready[1]), v ? 32'(i % 2 == 1) : 32'd0);
      check("t3_s_tready0", 32'(a_s_tready[0]), 32'd0);
      check("t3_grant", 32'(a_grant), v ? 32'd2 : 32'd0);
    end
    a_m_tready = 1'b1;
    wait_done("t3", 100);

    // Mid-packet stall on src0 while src1 waits.
    pkt(0, 3, 16'h4000);
    pkt(1, 2, 16'h4100);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!a_m_tvalid && c < 50);
    check("t4_first_beat_seen", 32'(a_m_tvalid), 32'd1);
    stall0 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("t4_stall_grant", 32'(a_grant), 32'd1);
      check("t4_stall_s_tready1", 32'(a_s_tready[1]), 32'd0);
      check("t4_stall_m_tvalid", 32'(a_m_tvalid), 32'd0);
    end
    stall0 = 1'b0;
    wait_done("t4", 100);

    // Reset during beat 2 of a src0 packet, right after a src0 packet set last_idx=0.
    pkt(0, 1, 16'h5000);
    pkt(0, 4, 16'h5100);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(a_m_tvalid && a_m_tdata == 16'h5100) && c < 80);
    check("t5_beat1_seen", 32'(a_m_tdata), 32'h5100);
    @(negedge clk);
    check("t5_beat2", 32'(a_m_tdata), 32'h5101);
    #2;
    arstn = 1'b0;
    #1;
    check("t5_rst_m_tvalid", 32'(a_m_tvalid), 32'd0);
    check("t5_rst_m_tdata", 32'(a_m_tdata), 32'd0);
    check("t5_rst_m_tlast", 32'(a_m_tlast), 32'd0);
    check("t5_rst_m_tid", 32'(a_m_tid), 32'd0);
    check("t5_rst_s_tready", 32'(a_s_tready), 32'd0);
    check("t5_rst_grant", 32'(a_grant), 32'd0);
    check("t5_rst_busy", 32'(a_busy), 32'd0);
    @(posedge clk);
    #3;
    q0.delete();
    sba.delete();
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    pkt(0, 1, 16'h5200);
    pkt(1, 1, 16'h5300);
    wait_done("t5", 100);

    // GAP_CYCLES=0, NUM_SRC=3, all requesting single-beat packets: tid 0,1,2,0.
    for (int i = 0; i < 4; i++) begin
      e.tid  = 2'(i % 3);
      e.data = 16'hB000 + 16'(i % 3);
      e.last = 1'b1;
      sbb.push_back(e);
    end
    b_s_tvalid = 3'b111;
    #1;
    check("t6_idle_m_tvalid", 32'(b_m_tvalid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t6_m_tvalid", 32'(b_m_tvalid), 32'(i % 2 == 1));
      check("t6_busy", 32'(b_busy), 32'(i % 2 == 1));
    end
    b_s_tvalid = 3'b000;
    @(negedge clk);
    check("t6_idle_after", 32'(b_busy), 32'd0);

    check("a_scoreboard_empty", 32'(sba.size()), 32'd0);
    check("b_scoreboard_empty", 32'(sbb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
